// File: rtl/hi_lo_muldiv_unit_if.sv
// Decode-side request and HI/LO result bundle between the pipeline and the
// iterative multiply/divide unit.
interface hi_lo_muldiv_unit_if;
  logic        instruction_valid;
  logic        hi_lo_register_write;
  logic [5:0]  ALU_function;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  modport master (
    output instruction_valid, hi_lo_register_write, ALU_function, operand_a, operand_b,
    input  hi, lo, busy, stall, done
  );

  modport slave (
    input  instruction_valid, hi_lo_register_write, ALU_function, operand_a, operand_b,
    output hi, lo, busy, stall, done
  );
endinterface

// File: rtl/hi_lo_muldiv_unit.sv
// HI/LO register file with a fixed 33-cycle shift-add multiplier and
// restoring divider (MULT/MULTU/DIV/DIVU, MTHI/MTLO, MFHI/MFLO).
module hi_lo_muldiv_unit (
  input  logic                  clk,
  input  logic                  reset_n,
  hi_lo_muldiv_unit_if.slave    bus
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} state_t;

  state_t      state;
  logic [31:0] hi_q, lo_q;
  logic        busy_q, done_q;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] rem;
  logic [31:0] opb;
  logic [31:0] raw_a;
  logic        neg_q, rem_neg, div_zero, op_div;

  logic        is_mul_f, is_div_f, is_signed_f, hl_move_f;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] prod_final;
  logic [31:0] quo_final, rem_final;

  always_comb begin
    is_mul_f    = (bus.ALU_function == F_MULT) || (bus.ALU_function == F_MULTU);
    is_div_f    = (bus.ALU_function == F_DIV)  || (bus.ALU_function == F_DIVU);
    is_signed_f = (bus.ALU_function == F_MULT) || (bus.ALU_function == F_DIV);
    hl_move_f   = (bus.ALU_function == F_MTHI) || (bus.ALU_function == F_MTLO) ||
                  (bus.ALU_function == F_MFHI) || (bus.ALU_function == F_MFLO);
    mag_a = (is_signed_f && bus.operand_a[31]) ? (~bus.operand_a + 32'd1) : bus.operand_a;
    mag_b = (is_signed_f && bus.operand_b[31]) ? (~bus.operand_b + 32'd1) : bus.operand_b;
  end

  // Multiplier sits in acc[31:0] and shifts out LSB-first as the product
  // fills in from the top; the dividend shares acc[31:0] and is replaced by quotient bits.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    div_shift = {rem, acc[31]};
    div_ge    = div_shift >= {1'b0, opb};
    div_diff  = div_shift[31:0] - opb;
    prod_final = neg_q   ? (~acc + 64'd1)        : acc;
    quo_final  = neg_q   ? (~acc[31:0] + 32'd1)  : acc[31:0];
    rem_final  = rem_neg ? (~rem + 32'd1)        : rem;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      rem      <= '0;
      opb      <= '0;
      raw_a    <= '0;
      neg_q    <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      op_div   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.instruction_valid && bus.hi_lo_register_write && (is_mul_f || is_div_f)) begin
            acc      <= {32'd0, mag_a};
            rem      <= '0;
            opb      <= mag_b;
            raw_a    <= bus.operand_a;
            neg_q    <= is_signed_f && (bus.operand_a[31] ^ bus.operand_b[31]);
            rem_neg  <= is_signed_f && bus.operand_a[31];
            div_zero <= (bus.operand_b == 32'd0);
            op_div   <= is_div_f;
            cnt      <= '0;
            busy_q   <= 1'b1;
            state    <= is_div_f ? DIV : MUL;
          end else if (bus.instruction_valid && (bus.ALU_function == F_MTHI)) begin
            hi_q <= bus.operand_a;
          end else if (bus.instruction_valid && (bus.ALU_function == F_MTLO)) begin
            lo_q <= bus.operand_a;
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[31:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state  <= FINISH;
            done_q <= 1'b1;
          end
        end
        DIV: begin
          acc[31:0] <= {acc[30:0], div_ge};
          rem       <= div_ge ? div_diff : div_shift[31:0];
          cnt       <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state  <= FINISH;
            done_q <= 1'b1;
          end
        end
        FINISH: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          cnt    <= '0;
          if (!op_div) begin
            hi_q <= prod_final[63:32];
            lo_q <= prod_final[31:0];
          end else if (div_zero) begin
            hi_q <= raw_a;
            lo_q <= '1;
          end else begin
            hi_q <= rem_final;
            lo_q <= quo_final;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = busy_q && bus.instruction_valid && (bus.hi_lo_register_write || hl_move_f);

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Directed bench for hi_lo_muldiv_unit: reset, HI/LO moves, multiply/divide
// results and latency, stalling while busy, reset abort and priority.
module tb_hi_lo_muldiv_unit;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef struct packed {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  hi_lo_muldiv_unit_if bus ();

  hi_lo_muldiv_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.instruction_valid    = 1'b0;
    bus.hi_lo_register_write = 1'b0;
    bus.ALU_function         = F_MFHI;
    bus.operand_a            = '0;
    bus.operand_b            = '0;
  endtask

  // Presents a request so it is sampled at the next edge; returns #1 after it.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic hlrw);
    @(negedge clk);
    bus.instruction_valid    = 1'b1;
    bus.hi_lo_register_write = hlrw;
    bus.ALU_function         = f;
    bus.operand_a            = a;
    bus.operand_b            = b;
    @(posedge clk);
    #1;
    bus.instruction_valid    = 1'b0;
    bus.operand_a            = 32'hDEADBEEF;
    bus.operand_b            = 32'h0BADF00D;
  endtask

  // Runs one op and samples cycles k+1..k+34 relative to the accept edge k.
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int done_at, output int done_cnt, output logic busy_first,
                       output logic busy_end, output logic [31:0] ohi, output logic [31:0] olo);
    done_at = 0;
    done_cnt = 0;
    busy_first = 1'b0;
    busy_end = 1'b1;
    ohi = '0;
    olo = '0;
    issue(f, a, b, 1'b1);
    for (int c = 1; c <= 34; c++) begin
      if (c == 1) busy_first = bus.busy;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
      end
      if (c == 34) begin
        busy_end = bus.busy;
        ohi = bus.hi;
        olo = bus.lo;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", bus.hi, 32'd0); end
    checks++; if (bus.lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", bus.lo, 32'd0); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    reset_n = 1'b1;
  endtask

  task automatic test_mthi_mtlo();
    issue(F_MTHI, 32'h12345678, 32'h0, 1'b0);
    checks++; if (bus.hi !== 32'h12345678) begin failures++; $display("FAIL mthi_hi got=%h exp=%h", bus.hi, 32'h12345678); end
    checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL mthi_lo got=%h exp=%h", bus.lo, 32'h0); end
    issue(F_MTLO, 32'hCAFEBABE, 32'h0, 1'b0);
    checks++; if (bus.lo !== 32'hCAFEBABE) begin failures++; $display("FAIL mtlo_lo got=%h exp=%h", bus.lo, 32'hCAFEBABE); end
    checks++; if (bus.hi !== 32'h12345678) begin failures++; $display("FAIL mtlo_hi got=%h exp=%h", bus.hi, 32'h12345678); end
    issue(F_MFHI, 32'h55555555, 32'h0, 1'b0);
    checks++; if (bus.hi !== 32'h12345678 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL mfhi_noeffect hi=%h busy=%b exp hi=%h busy=0", bus.hi, bus.busy, 32'h12345678);
    end
  endtask

  task automatic run_vectors(input string tag, input vec_t v [4]);
    int done_at, done_cnt;
    logic busy_first, busy_end;
    logic [31:0] ohi, olo;
    for (int i = 0; i < 4; i++) begin
      do_op(v[i].f, v[i].a, v[i].b, done_at, done_cnt, busy_first, busy_end, ohi, olo);
      checks++; if (busy_first !== 1'b1) begin failures++; $display("FAIL %s[%0d]_busy_start got=%b exp=1", tag, i, busy_first); end
      checks++; if (done_at != 33 || done_cnt != 1) begin
        failures++; $display("FAIL %s[%0d]_done_timing first=%0d pulses=%0d exp first=33 pulses=1", tag, i, done_at, done_cnt);
      end
      checks++; if (busy_end !== 1'b0) begin failures++; $display("FAIL %s[%0d]_busy_end got=%b exp=0", tag, i, busy_end); end
      checks++; if (ohi !== v[i].eh) begin failures++; $display("FAIL %s[%0d]_hi got=%h exp=%h", tag, i, ohi, v[i].eh); end
      checks++; if (olo !== v[i].el) begin failures++; $display("FAIL %s[%0d]_lo got=%h exp=%h", tag, i, olo, v[i].el); end
    end
  endtask

  task automatic test_mul();
    vec_t v [4];
    v[0] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    v[1] = '{F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    v[2] = '{F_MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000};
    v[3] = '{F_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E};
    run_vectors("mul", v);
    v[0] = '{F_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    v[1] = '{F_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    v[2] = '{F_MULT,  32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    v[3] = '{F_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    run_vectors("mul2", v);
  endtask

  task automatic test_div();
    vec_t v [4];
    v[0] = '{F_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[1] = '{F_DIVU, 32'h00000009, 32'h00000000, 32'h00000009, 32'hFFFFFFFF};
    v[2] = '{F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    v[3] = '{F_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    run_vectors("div", v);
    v[0] = '{F_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    v[1] = '{F_DIV,  32'hFFFFFFF7, 32'h00000000, 32'hFFFFFFF7, 32'hFFFFFFFF};
    v[2] = '{F_DIVU, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999};
    v[3] = '{F_DIVU, 32'h00000003, 32'h00000008, 32'h00000003, 32'h00000000};
    run_vectors("div2", v);
  endtask

  task automatic test_stall_while_busy();
    issue(F_MTHI, 32'hAAAA0001, 32'h0, 1'b0);
    issue(F_MTLO, 32'hBBBB0002, 32'h0, 1'b0);
    issue(F_DIVU, 32'h00000064, 32'h00000007, 1'b1);
    for (int c = 1; c <= 33; c++) begin
      bus.instruction_valid    = 1'b1;
      bus.hi_lo_register_write = (c > 3);
      bus.ALU_function         = (c > 3) ? F_MULTU : F_MFLO;
      bus.operand_a            = 32'h00000003;
      bus.operand_b            = 32'h00000005;
      #1;
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL stall_c%0d got=%b exp=1", c, bus.stall); end
      checks++; if (bus.hi !== 32'hAAAA0001 || bus.lo !== 32'hBBBB0002) begin
        failures++; $display("FAIL stall_hold_c%0d hi=%h lo=%h exp hi=%h lo=%h", c, bus.hi, bus.lo, 32'hAAAA0001, 32'hBBBB0002);
      end
      @(posedge clk);
      #1;
    end
    #1;
    checks++; if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL stall_release stall=%b busy=%b exp 0/0", bus.stall, bus.busy);
    end
    checks++; if (bus.hi !== 32'h2 || bus.lo !== 32'hE) begin
      failures++; $display("FAIL stall_first_result hi=%h lo=%h exp hi=%h lo=%h", bus.hi, bus.lo, 32'h2, 32'hE);
    end
    @(posedge clk);
    #1;
    bus.instruction_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL stall_second_accept busy=%b exp=1", bus.busy); end
    repeat (32) @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL stall_second_done got=%b exp=1", bus.done); end
    @(posedge clk);
    #1;
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'hF || bus.busy !== 1'b0) begin
      failures++; $display("FAIL stall_second_result hi=%h lo=%h busy=%b exp hi=0 lo=f busy=0", bus.hi, bus.lo, bus.busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    pulses = 0;
    issue(F_MTHI, 32'h11112222, 32'h0, 1'b0);
    issue(F_MULT, 32'hFFFFFFFD, 32'h00000007, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      failures++; $display("FAIL reset_mid_hilo hi=%h lo=%h exp 0/0", bus.hi, bus.lo);
    end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_mid_flags busy=%b done=%b exp 0/0", bus.busy, bus.done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    checks++; if (pulses != 0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      failures++; $display("FAIL reset_mid_no_done pulses=%0d hi=%h lo=%h exp 0/0/0", pulses, bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    reset_n = 1'b0;
    bus.instruction_valid    = 1'b1;
    bus.hi_lo_register_write = 1'b0;
    bus.ALU_function         = F_MTHI;
    bus.operand_a            = 32'hAAAA5555;
    @(posedge clk);
    #1;
    checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_prio_mthi got=%h exp=%h", bus.hi, 32'h0); end
    bus.hi_lo_register_write = 1'b1;
    bus.ALU_function         = F_MULTU;
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_prio_accept busy=%b exp=0", bus.busy); end
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int done_at, done_cnt;
    logic busy_first, busy_end;
    logic [31:0] ohi, olo;
    do_op(F_MULTU, 32'h00000006, 32'h00000007, done_at, done_cnt, busy_first, busy_end, ohi, olo);
    checks++; if (ohi !== 32'h0 || olo !== 32'h2A || done_at != 33) begin
      failures++; $display("FAIL b2b_first hi=%h lo=%h done_at=%0d exp hi=0 lo=2a done_at=33", ohi, olo, done_at);
    end
    do_op(F_DIVU, 32'h0000002A, 32'h00000005, done_at, done_cnt, busy_first, busy_end, ohi, olo);
    checks++; if (ohi !== 32'h2 || olo !== 32'h8 || done_at != 33 || busy_first !== 1'b1) begin
      failures++; $display("FAIL b2b_second hi=%h lo=%h done_at=%0d busy_first=%b exp hi=2 lo=8 33 1", ohi, olo, done_at, busy_first);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_mthi_mtlo();
    test_mul();
    test_div();
    test_stall_while_busy();
    idle_inputs();
    test_reset_mid_op();
    test_reset_priority();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
